// File: rtl/game_timer.sv
// Countdown game timer: prescaled count ticks, a run/pause/expired state machine and
// saturating bonus/penalty adjustment of the remaining time.
module game_timer #(
  parameter int WIDTH    = 8,
  parameter int INIT_VAL = 20,
  parameter int MAX_VAL  = 255,
  parameter int TICK_DIV = 100000000,
  parameter int BONUS    = 1,
  parameter int PENALTY  = 1,
  parameter int WARN_VAL = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             bonus,
  input  logic             penalty,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             expired,
  output logic             expire_pulse,
  output logic             warn
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = WIDTH + 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_d;
  logic             tick_d, expire_pulse_d;
  logic             dec;

  logic signed [SW-1:0] cur_s, dec_s, bonus_s, penalty_s, sum;
  logic [WIDTH-1:0]     sat;

  assign dec = (presc_q == PW'(TICK_DIV - 1));

  // Headroom of two bits keeps count+BONUS and -1-PENALTY representable before saturation.
  always_comb begin
    cur_s     = $signed({2'b00, count});
    dec_s     = dec ? SW'(1) : SW'(0);
    bonus_s   = bonus ? SW'(BONUS) : SW'(0);
    penalty_s = penalty ? SW'(PENALTY) : SW'(0);
    sum       = cur_s - dec_s + bonus_s - penalty_s;
    if (sum <= $signed(SW'(0))) begin
      sat = '0;
    end else if (sum > $signed(SW'(MAX_VAL))) begin
      sat = WIDTH'(MAX_VAL);
    end else begin
      sat = sum[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    count_d        = count;
    tick_d         = 1'b0;
    expire_pulse_d = 1'b0;
    if (load) begin
      count_d = (load_val > WIDTH'(MAX_VAL)) ? WIDTH'(MAX_VAL) : load_val;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            presc_d = dec ? '0 : presc_q + PW'(1);
            tick_d  = dec;
            if (sat == '0) begin
              count_d        = '0;
              state_d        = EXPIRED;
              expire_pulse_d = 1'b1;
            end else begin
              count_d = sat;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      count        <= WIDTH'(INIT_VAL);
      tick         <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      count        <= count_d;
      tick         <= tick_d;
      expire_pulse <= expire_pulse_d;
    end
  end

  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign warn    = running && (count <= WIDTH'(WARN_VAL));

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed scenarios plus randomized traffic against a
// cycle-level arithmetic reference model.
module tb_game_timer;

  localparam int W    = 8;
  localparam int INIT = 20;
  localparam int MAXV = 100;
  localparam int TDIV = 4;
  localparam int BON  = 3;
  localparam int PEN  = 2;
  localparam int WARNV = 5;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0, start = 1'b0, pause = 1'b0, bonus = 1'b0, penalty = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tick, running, expired, expire_pulse, warn;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state = M_IDLE;
  int m_count = INIT;
  int m_presc = 0;
  int m_tick  = 0;
  int m_xp    = 0;

  game_timer #(
    .WIDTH   (W),
    .INIT_VAL(INIT),
    .MAX_VAL (MAXV),
    .TICK_DIV(TDIV),
    .BONUS   (BON),
    .PENALTY (PEN),
    .WARN_VAL(WARNV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .bonus       (bonus),
    .penalty     (penalty),
    .load        (load),
    .load_val    (load_val),
    .count       (count),
    .tick        (tick),
    .running     (running),
    .expired     (expired),
    .expire_pulse(expire_pulse),
    .warn        (warn)
  );

  always #5 clk = ~clk;

  function automatic int m_warn();
    return (m_state == M_RUN && m_count <= WARNV) ? 1 : 0;
  endfunction

  // Advance the model by one clock using the inputs being presented this cycle.
  function automatic void model_update();
    int nxt;
    int d;
    m_tick = 0;
    m_xp   = 0;
    if (reset) begin
      m_state = M_IDLE; m_count = INIT; m_presc = 0;
    end else if (load) begin
      m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_presc = 0;
      m_state = M_IDLE;
    end else if (m_state == M_IDLE) begin
      if (start) begin m_state = M_RUN; m_presc = 0; end
    end else if (m_state == M_PAUSED) begin
      if (start) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (pause) m_state = M_PAUSED;
      else begin
        d = (m_presc == TDIV - 1) ? 1 : 0;
        m_presc = d ? 0 : m_presc + 1;
        m_tick = d;
        nxt = m_count - d + (bonus ? BON : 0) - (penalty ? PEN : 0);
        if (nxt > MAXV) nxt = MAXV;
        if (nxt <= 0) begin
          m_count = 0; m_state = M_EXP; m_xp = 1;
        end else m_count = nxt;
      end
    end
  endfunction

  task automatic step(input logic s, input logic p, input logic b, input logic pn,
                      input logic ld, input logic [W-1:0] lv, input logic rs);
    start = s; pause = p; bonus = b; penalty = pn; load = ld; load_val = lv; reset = rs;
    @(posedge clk);
    model_update();
    #1;
    start = 0; pause = 0; bonus = 0; penalty = 0; load = 0; reset = 0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, '0, 1);
    checks++;
    if (count !== 8'(INIT) || running !== 1'b0 || expired !== 1'b0 || tick !== 1'b0 ||
        expire_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d run=%b exp=%b tick=%b xp=%b, want count=%0d all 0",
               count, running, expired, tick, expire_pulse, INIT);
    end
  endtask

  task automatic test_countdown();
    int xp_seen = 0;
    step(1, 0, 0, 0, 0, '0, 0);
    for (int c = 1; c <= 80; c++) begin
      step(0, 0, 0, 0, 0, '0, 0);
      checks++;
      if (count !== 8'(m_count) || tick !== 1'(m_tick)) begin
        errors++;
        $display("FAIL countdown c%0d: count=%0d tick=%b, want %0d %0d", c, count, tick,
                 m_count, m_tick);
      end
      if (c == 4) begin
        checks++;
        if (count !== 8'd19) begin
          errors++; $display("FAIL first_dec: count=%0d want 19", count);
        end
      end
      if (expire_pulse === 1'b1) xp_seen++;
    end
    checks++;
    if (count !== 8'd0 || expired !== 1'b1 || running !== 1'b0 || expire_pulse !== 1'b1 ||
        xp_seen != 1) begin
      errors++;
      $display("FAIL expiry80: count=%0d exp=%b run=%b xp=%b seen=%0d, want 0 1 0 1 1",
               count, expired, running, expire_pulse, xp_seen);
    end
    step(0, 0, 0, 0, 0, '0, 0);
    checks++;
    if (expire_pulse !== 1'b0 || expired !== 1'b1) begin
      errors++;
      $display("FAIL xp_width: xp=%b exp=%b, want 0 1", expire_pulse, expired);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 0, 1, 8'd99, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    step(0, 0, 1, 0, 0, '0, 0);
    checks++;
    if (count !== 8'(MAXV)) begin
      errors++; $display("FAIL sat_bonus: count=%0d want %0d", count, MAXV);
    end
    step(0, 0, 1, 0, 0, '0, 0);
    checks++;
    if (count !== 8'(MAXV) || count !== 8'(m_count)) begin
      errors++; $display("FAIL sat_hold: count=%0d want %0d", count, MAXV);
    end
  endtask

  task automatic test_penalty_expire();
    step(0, 0, 0, 0, 1, 8'd1, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 1, 0, '0, 0);
    checks++;
    if (count !== 8'd0 || expired !== 1'b1 || expire_pulse !== 1'b1) begin
      errors++;
      $display("FAIL pen_expire: count=%0d exp=%b xp=%b, want 0 1 1", count, expired,
               expire_pulse);
    end
    step(1, 0, 0, 0, 0, '0, 0);
    step(0, 0, 1, 0, 0, '0, 0);
    checks++;
    if (count !== 8'd0 || expired !== 1'b1 || running !== 1'b0 || expire_pulse !== 1'b0) begin
      errors++;
      $display("FAIL exp_sticky: count=%0d exp=%b run=%b xp=%b, want 0 1 0 0", count, expired,
               running, expire_pulse);
    end
  endtask

  task automatic test_pause();
    int guard = 0;
    step(0, 0, 0, 0, 1, 8'd50, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    while (tick !== 1'b1 && guard < 10) begin
      step(0, 0, 0, 0, 0, '0, 0);
      guard++;
    end
    checks++;
    if (tick !== 1'b1 || count !== 8'd49) begin
      errors++; $display("FAIL pause_pre: tick=%b count=%0d, want 1 49", tick, count);
    end
    idle_steps(2);
    step(0, 1, 1, 1, 0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 0, '0, 0);
      checks++;
      if (count !== 8'd49 || tick !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold%0d: count=%0d tick=%b run=%b, want 49 0 0", i, count, tick,
                 running);
      end
    end
    step(1, 0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, 0, '0, 0);
    checks++;
    if (count !== 8'd49 || tick !== 1'b0) begin
      errors++; $display("FAIL resume1: count=%0d tick=%b, want 49 0", count, tick);
    end
    step(0, 0, 0, 0, 0, '0, 0);
    checks++;
    if (count !== 8'd48 || tick !== 1'b1) begin
      errors++; $display("FAIL resume2: count=%0d tick=%b, want 48 1", count, tick);
    end
  endtask

  task automatic test_coincident();
    step(0, 0, 0, 0, 1, 8'd10, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    idle_steps(3);
    step(0, 0, 1, 0, 0, '0, 0);
    checks++;
    if (count !== 8'(10 - 1 + BON) || tick !== 1'b1) begin
      errors++; $display("FAIL bonus_dec: count=%0d tick=%b, want %0d 1", count, tick, 10 - 1 + BON);
    end
    idle_steps(3);
    step(0, 0, 0, 1, 0, '0, 0);
    checks++;
    if (count !== 8'(10 - 1 + BON - 1 - PEN)) begin
      errors++; $display("FAIL pen_dec: count=%0d want %0d", count, 10 - 2 + BON - PEN);
    end
    step(0, 0, 0, 0, 1, 8'd7, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    idle_steps(4);
    checks++;
    if (count !== 8'd6 || warn !== 1'b0) begin
      errors++; $display("FAIL warn_low: count=%0d warn=%b, want 6 0", count, warn);
    end
    idle_steps(4);
    checks++;
    if (count !== 8'd5 || warn !== 1'b1) begin
      errors++; $display("FAIL warn_rise: count=%0d warn=%b, want 5 1", count, warn);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 1, 8'd9, 0);
    step(1, 0, 0, 0, 0, '0, 0);
    idle_steps(8);
    checks++;
    if (count !== 8'd7 || running !== 1'b1) begin
      errors++; $display("FAIL mid_pre: count=%0d run=%b, want 7 1", count, running);
    end
    idle_steps(3);
    step(0, 0, 1, 0, 0, '0, 1);
    checks++;
    if (count !== 8'(INIT) || running !== 1'b0 || expired !== 1'b0 || tick !== 1'b0 ||
        expire_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d run=%b exp=%b tick=%b xp=%b, want %0d 0 0 0 0",
               count, running, expired, tick, expire_pulse, INIT);
    end
  endtask

  task automatic test_clamp();
    step(0, 0, 0, 0, 1, 8'd200, 0);
    checks++;
    if (count !== 8'(MAXV) || running !== 1'b0) begin
      errors++; $display("FAIL clamp: count=%0d run=%b, want %0d 0", count, running, MAXV);
    end
    step(0, 0, 0, 0, 1, 8'd0, 0);
    checks++;
    if (count !== 8'd0 || expired !== 1'b0 || running !== 1'b0 || expire_pulse !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: count=%0d exp=%b run=%b xp=%b, want 0 0 0 0", count, expired,
               running, expire_pulse);
    end
  endtask

  task automatic test_random();
    step(0, 0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(15) == 0), ($urandom_range(5) == 0),
           ($urandom_range(5) == 0), ($urandom_range(63) == 0), 8'($urandom_range(255)),
           ($urandom_range(499) == 0));
      checks++;
      if (count !== 8'(m_count) || tick !== 1'(m_tick) || expire_pulse !== 1'(m_xp) ||
          running !== (m_state == M_RUN) || expired !== (m_state == M_EXP) ||
          warn !== 1'(m_warn())) begin
        errors++;
        $display("FAIL random%0d: count=%0d tick=%b xp=%b run=%b exp=%b warn=%b, want %0d %0d %0d %0d %0d %0d",
                 i, count, tick, expire_pulse, running, expired, warn, m_count, m_tick, m_xp,
                 (m_state == M_RUN), (m_state == M_EXP), m_warn());
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_countdown();
    test_saturate();
    test_penalty_expire();
    test_pause();
    test_coincident();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
